neuron_backprop: RTL
====================

NEURON_BACKPROP -- requirements
Module: neuron_backprop

Interface
REQ-001 Parameter: N, default 16, number of neuron inputs; SHALL be 1 to 64.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  one-cycle request to begin a backprop pass.
REQ-005 Port: busy  output  1  high while a pass is in progress.
REQ-006 Port: done  output  1  one-cycle pulse when expected_in is complete.
REQ-007 Port: in  input  zero2one_t[N]  neuron inputs of the evaluated sample.
REQ-008 Port: out  input  zero2one_t  neuron output actually produced.
REQ-009 Port: expected_out  input  zero2one_t  target output from the downstream layer.
REQ-010 Port: weights  input  frac_t[N]  current neuron weights.
REQ-011 Port: expected_in  output  zero2one_t[N]  propagated targets for the upstream layer.
REQ-012 Types: zero2one_t SHALL be 8-bit unsigned (255 = 1.0); frac_t SHALL be 16-bit signed Q8.8; elaboration SHALL fail on any other width.

Function
REQ-013 FSM states SHALL be IDLE, ITER and DONE; reset state is IDLE.
REQ-014 IDLE + start: capture in, out, expected_out and weights into internal registers; clear index to 0; go to ITER. Inputs are not sampled again during the pass.
REQ-015 Error SHALL be err = expected_out - out, computed as a 9-bit signed value in the capture cycle.
REQ-016 ITER: exactly one element i = index per cycle. p = err * weights[i] (25-bit signed); d = p >>> 8 (arithmetic shift, floor); expected_in[i] = clamp(in[i] + d, 0, 255).
REQ-017 ITER: index increments each cycle; after writing element N-1, go to DONE.
REQ-018 DONE: done = 1 for exactly one cycle, then IDLE.
REQ-019 Latency: with start in cycle 0, done SHALL be high in cycle N+1.
REQ-020 busy SHALL be high in ITER and DONE and low in IDLE.
REQ-021 start while busy SHALL be ignored; start in the same cycle as done SHALL be ignored.
REQ-022 expected_in elements not yet written in the current pass SHALL hold their previous values; all elements SHALL hold after done until the next accepted start.
REQ-023 Clamping SHALL saturate independently per element; there is no wrap-around.
REQ-024 err = 0 SHALL give expected_in[i] = in[i] for every i.

Reset
REQ-025 rst high: state = IDLE, index = 0, busy = 0, done = 0, every expected_in[i] = 0, captured registers = 0.
REQ-026 rst during ITER or DONE SHALL abort the pass; no done pulse is generated for the aborted pass.
REQ-027 start while rst is high SHALL be ignored.

Configuration
REQ-028 Macro NEURON_BACKPROP_LR_EN defined: add port lr_shift  input  3  learning-rate shift, captured at start; d = p >>> (8 + lr_shift).
REQ-029 Macro NEURON_BACKPROP_LR_EN undefined: port lr_shift absent; d = p >>> 8; all other behaviour is identical.

Verification
REQ-030 N=4, weights[0]=0x0100, in[0]=100, out=50, expected_out=80 -> expected_in[0]=130; done in cycle 5.
REQ-031 weights[0]=0xFE00 (-2.0), in[0]=50, out=0, expected_out=100 -> expected_in[0]=0 (low clamp); weights[1]=0x0200, in[1]=200, same err -> expected_in[1]=255 (high clamp).
REQ-032 Pulse start again in cycle 2 of a pass (N=4) -> ignored; exactly one done pulse in cycle 5; busy stays high in cycles 1-5.
REQ-033 Assert rst in cycle 3 of a pass -> next cycle busy=0, expected_in all 0, no done pulse; a subsequent start completes normally.
REQ-034 LR_EN defined, lr_shift=2, weights[0]=0x0100, in[0]=100, err=40 -> expected_in[0]=110; without LR_EN, same stimulus -> 140.

Source files
------------

// File: rtl/neuron_backprop.sv
// -----------------------------------------------------------------------------
// neuron_backprop
//
// Purpose:
//   Propagates a training target back through a single neuron. A pass begins
//   when start is accepted. The block captures the inputs, the produced output,
//   the target output and the weights, then computes err = expected_out - out.
//   It then walks the N inputs one element per cycle:
//     expected_in[i] = clamp(in[i] + ((err * weights[i]) >>> shift), 0, 255)
//   The shift is 8 in the default build.
//
// Optional feature:
//   NEURON_BACKPROP_LR_EN - adds a 3-bit lr_shift input. It is captured with
//   the other operands, and the shift becomes 8 + lr_shift.
//
// Ports:
//   clk           single clock, rising edge
//   rst           synchronous active-high reset
//   start         one-cycle request to begin a pass (ignored while busy)
//   lr_shift      learning-rate shift (only with NEURON_BACKPROP_LR_EN)
//   busy          high while a pass is in progress (ITER and DONE)
//   done          one-cycle pulse once every expected_in element is written
//   in[N]         neuron inputs of the evaluated sample (0..255 = 0.0..1.0)
//   out           neuron output actually produced
//   expected_out  target output from the downstream layer
//   weights[N]    current weights, signed Q8.8
//   expected_in[N] propagated targets for the upstream layer
// -----------------------------------------------------------------------------
package neuron_backprop_pkg;
  typedef logic [7:0]         zero2one_t;
  typedef logic signed [15:0] frac_t;
endpackage

module neuron_backprop
  import neuron_backprop_pkg::*;
#(
  parameter int N = 16
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      start,
`ifdef NEURON_BACKPROP_LR_EN
  input  logic [2:0] lr_shift,
`endif
  output logic      busy,
  output logic      done,
  input  zero2one_t in           [N],
  input  zero2one_t out,
  input  zero2one_t expected_out,
  input  frac_t     weights      [N],
  output zero2one_t expected_in  [N]
);

  // Elaboration guards on the parameter range and on the fixed type widths.
  if (N < 1 || N > 64) begin : g_bad_n
    $error("neuron_backprop: N must be within 1..64");
  end
  if ($bits(zero2one_t) != 8) begin : g_bad_z2o
    $error("neuron_backprop: zero2one_t must be 8 bits wide");
  end
  if ($bits(frac_t) != 16) begin : g_bad_frac
    $error("neuron_backprop: frac_t must be 16 bits wide");
  end

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic             cap_s;
  logic             wr_s;
  logic             busy_r;
  logic             done_r;
  logic [IDX_W-1:0] idx_r;

  // Operands frozen for the whole pass.
  zero2one_t        in_r     [N];
  frac_t            w_r      [N];
  logic signed [8:0] err_r;
`ifdef NEURON_BACKPROP_LR_EN
  logic [2:0]       lr_r;
`endif

  zero2one_t        exp_in_r [N];

  // Per-element datapath signals.
  zero2one_t          in_sel_s;
  frac_t              w_sel_s;
  logic [3:0]         shamt_s;
  logic signed [24:0] p_s;
  logic signed [24:0] d_s;
  logic signed [25:0] sum_s;
  zero2one_t          wr_val_s;

  // Saturates a signed sum to the 0..255 range; there is no wrap-around.
  function automatic zero2one_t clamp_u8(input logic signed [25:0] v);
    zero2one_t r;
    if (v < 26'sd0) begin
      r = 8'd0;
    end else if (v > 26'sd255) begin
      r = 8'd255;
    end else begin
      r = v[7:0];
    end
    return r;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and control decode. A start is accepted only in IDLE, so a start
  // in ITER or DONE (including in the done cycle) is dropped.
  always_comb begin
    state_next_s = state_r;
    cap_s        = 1'b0;
    wr_s         = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = ITER;
          cap_s        = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      ITER: begin
        wr_s = 1'b1;
        if (idx_r == LAST_IDX) begin
          state_next_s = DONE;
        end else begin
          state_next_s = ITER;
        end
      end
      DONE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Registered status outputs, decoded from the next state so that they line up
  // with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_next_s != IDLE);
      done_r <= (state_next_s == DONE);
    end
  end

  // Element select and arithmetic for the element addressed by idx_r.
  // Both factors are sign-extended to 25 bits. The true product always fits in
  // 25 signed bits, so the truncated product is exact.
  always_comb begin
    in_sel_s = in_r[idx_r];
    w_sel_s  = w_r[idx_r];
`ifdef NEURON_BACKPROP_LR_EN
    shamt_s  = 4'd8 + {1'b0, lr_r};
`else
    shamt_s  = 4'd8;
`endif
    p_s      = $signed({{16{err_r[8]}}, err_r}) * $signed({{9{w_sel_s[15]}}, w_sel_s});
    d_s      = p_s >>> shamt_s;
    sum_s    = $signed({18'd0, in_sel_s}) + $signed({d_s[24], d_s});
    wr_val_s = clamp_u8(sum_s);
  end

  // Operand capture, index walk and result write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r <= '0;
      err_r <= 9'sd0;
`ifdef NEURON_BACKPROP_LR_EN
      lr_r  <= 3'd0;
`endif
      for (int i = 0; i < N; i++) begin
        in_r[i]     <= 8'd0;
        w_r[i]      <= 16'sd0;
        exp_in_r[i] <= 8'd0;
      end
    end else if (cap_s) begin
      in_r  <= in;
      w_r   <= weights;
      err_r <= $signed({1'b0, expected_out}) - $signed({1'b0, out});
`ifdef NEURON_BACKPROP_LR_EN
      lr_r  <= lr_shift;
`endif
      idx_r <= '0;
    end else if (wr_s) begin
      exp_in_r[idx_r] <= wr_val_s;
      idx_r           <= idx_r + IDX_W'(1);
    end else begin
      idx_r <= idx_r;
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign expected_in = exp_in_r;

endmodule
